// File: rtl/bounce_gen_if.sv
// rtl/bounce_gen_if.sv - level request / bouncing output bundle for bounce_gen
interface bounce_gen_if;
   logic       level_in;
   logic       data_out;
   logic       busy;
   logic       settled;
   logic [3:0] toggle_cnt;

   modport master (
      output level_in,
      input  data_out,
      input  busy,
      input  settled,
      input  toggle_cnt
   );

   modport slave (
      input  level_in,
      output data_out,
      output busy,
      output settled,
      output toggle_cnt
   );
endinterface

// File: rtl/bounce_gen.sv
// rtl/bounce_gen.sv - contact-bounce emulator: glitch burst then settle hold
// Define BOUNCE_GEN_FIXED_EN for deterministic mode (no LFSR, k=MAX_PAIRS, interval=TOGGLE_MIN).
module bounce_gen #(
   parameter int          MAX_PAIRS     = 5,
   parameter int          TOGGLE_MIN    = 4,
   parameter int          IW            = 4,
   parameter int          SETTLE_CYCLES = 65536,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input logic         clk,
   input logic         rst_n,
   bounce_gen_if.slave bus
);
   localparam int              ICW         = $clog2(TOGGLE_MIN + (1 << IW));
   localparam int              SCW         = $clog2(SETTLE_CYCLES);
   localparam logic [SCW-1:0]  SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
   localparam logic [2:0]      MAXP        = 3'(MAX_PAIRS);

   typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

   state_t         state, state_nx;
   logic           data_q, data_nx;
   logic           target_q, target_nx;
   logic           busy_q;
   logic           settled_q, settled_nx;
   logic [3:0]     tcnt_q, tcnt_nx;
   logic [3:0]     rem_q, rem_nx;
   logic [ICW-1:0] ivl_q, ivl_nx;
   logic [SCW-1:0] stl_q, stl_nx;

   logic [2:0]     k;
   logic [ICW-1:0] ivl_load;
   logic           start;
   logic           ivl_zero;
   logic           stl_zero;

`ifdef BOUNCE_GEN_FIXED_EN
   assign k        = MAXP;
   assign ivl_load = ICW'(TOGGLE_MIN - 1);
`else
   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   logic [15:0] lfsr;

   // Galois form of x^16+x^14+x^13+x^11+1; free-running in every state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lfsr <= SEED;
      else
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   assign k        = (lfsr[2:0] > MAXP) ? MAXP : lfsr[2:0];
   assign ivl_load = ICW'(TOGGLE_MIN - 1) + ICW'(lfsr[IW+2:3]);
`endif

   assign start    = (bus.level_in != data_q);
   assign ivl_zero = (ivl_q == '0);
   assign stl_zero = (stl_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         data_q    <= 1'b0;
         target_q  <= 1'b0;
         busy_q    <= 1'b0;
         settled_q <= 1'b0;
         tcnt_q    <= 4'd0;
         rem_q     <= 4'd0;
         ivl_q     <= '0;
         stl_q     <= '0;
      end else begin
         state     <= state_nx;
         data_q    <= data_nx;
         target_q  <= target_nx;
         busy_q    <= (state_nx != IDLE);
         settled_q <= settled_nx;
         tcnt_q    <= tcnt_nx;
         rem_q     <= rem_nx;
         ivl_q     <= ivl_nx;
         stl_q     <= stl_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (k != 3'd0) ? BOUNCE : SETTLE;
         BOUNCE:  if (ivl_zero && rem_q == 4'd1) state_nx = SETTLE;
         SETTLE:  if (stl_zero) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      data_nx    = data_q;
      target_nx  = target_q;
      settled_nx = 1'b0;
      tcnt_nx    = tcnt_q;
      rem_nx     = rem_q;
      ivl_nx     = ivl_q;
      // Settle counter is preloaded outside SETTLE so it is ready on entry
      stl_nx     = SETTLE_LOAD;
      case (state)
         IDLE: begin
            if (start) begin
               data_nx   = ~data_q;
               target_nx = bus.level_in;
               tcnt_nx   = 4'd1;
               rem_nx    = {k, 1'b0};
               ivl_nx    = ivl_load;
            end
         end
         BOUNCE: begin
            if (ivl_zero) begin
               data_nx = ~data_q;
               tcnt_nx = (tcnt_q == 4'hF) ? tcnt_q : tcnt_q + 4'd1;
               rem_nx  = rem_q - 4'd1;
               ivl_nx  = ivl_load;
            end else begin
               ivl_nx  = ivl_q - ICW'(1);
            end
         end
         SETTLE: begin
            data_nx    = target_q;
            settled_nx = stl_zero;
            stl_nx     = stl_zero ? stl_q : stl_q - SCW'(1);
         end
         default: ;
      endcase
   end

   assign bus.data_out   = data_q;
   assign bus.busy       = busy_q;
   assign bus.settled    = settled_q;
   assign bus.toggle_cnt = tcnt_q;
endmodule

// File: tb/tb_bounce_gen.sv
// tb/tb_bounce_gen.sv - randomized bench for bounce_gen against an event-level reference model
module tb_bounce_gen;
   localparam int          MAX_PAIRS  = 5;
   localparam int          TOGGLE_MIN = 4;
   localparam int          IW         = 4;
   localparam int          SETTLE     = 16;
   localparam logic [15:0] SEED       = 16'hACE1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bounce_gen_if ifc();

   bounce_gen #(
      .MAX_PAIRS     (MAX_PAIRS),
      .TOGGLE_MIN    (TOGGLE_MIN),
      .IW            (IW),
      .SETTLE_CYCLES (SETTLE),
      .LFSR_SEED     (SEED)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   int     n_vec = 0;
   int     n_err = 0;
   longint cyc   = 0;
   int     events = 0;

   // reference model: whole-event plan expressed as absolute edge times
   logic        m_data, m_busy, m_settled, m_target;
   int          m_cnt, m_left;
   longint      m_next, m_settle_at;
   logic [15:0] m_lfsr;

   logic        p_data, p_busy;
   longint      last_tog;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] lfsr_step(logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic int pairs_of(logic [15:0] r);
`ifdef BOUNCE_GEN_FIXED_EN
      return MAX_PAIRS;
`else
      int lo;
      lo = int'(r) % 8;
      return (lo > MAX_PAIRS) ? MAX_PAIRS : lo;
`endif
   endfunction

   function automatic int gap_of(logic [15:0] r);
`ifdef BOUNCE_GEN_FIXED_EN
      return TOGGLE_MIN;
`else
      return TOGGLE_MIN + ((int'(r) >> 3) % (1 << IW));
`endif
   endfunction

   task automatic model_reset();
      m_data = 0; m_busy = 0; m_settled = 0; m_target = 0;
      m_cnt = 0; m_left = 0; m_next = 0; m_settle_at = 0;
      m_lfsr = SEED;
      p_data = 0; p_busy = 0; last_tog = 0;
   endtask

   task automatic model_edge(logic lin);
      m_settled = 0;
      if (!m_busy) begin
         if (lin != m_data) begin
            m_data   = ~m_data;
            m_target = lin;
            m_cnt    = 1;
            m_left   = 2 * pairs_of(m_lfsr);
            m_busy   = 1;
            events++;
            if (m_left > 0) m_next = cyc + gap_of(m_lfsr);
            else            m_settle_at = cyc + SETTLE;
         end
      end else if (m_left > 0) begin
         if (cyc == m_next) begin
            m_data = ~m_data;
            m_cnt  = (m_cnt >= 15) ? 15 : m_cnt + 1;
            m_left--;
            if (m_left > 0) m_next = cyc + gap_of(m_lfsr);
            else            m_settle_at = cyc + SETTLE;
         end
      end else if (cyc == m_settle_at) begin
         m_settled = 1;
         m_busy    = 0;
      end
      m_lfsr = lfsr_step(m_lfsr);
      cyc++;
   endtask

   task automatic check_outputs();
      chk("data_out",   ifc.data_out,   m_data);
      chk("busy",       ifc.busy,       m_busy);
      chk("settled",    ifc.settled,    m_settled);
      chk("toggle_cnt", ifc.toggle_cnt, m_cnt[3:0]);
      // independent checks on the observed waveform itself
      if (ifc.data_out != p_data) begin
         if (p_busy && ifc.busy) begin
            chk("gap_min", (cyc - 1 - last_tog) >= TOGGLE_MIN, 1);
            chk("gap_max", (cyc - 1 - last_tog) <= TOGGLE_MIN + 15, 1);
         end
         last_tog = cyc - 1;
      end
      if (ifc.settled) begin
         chk("n_odd",     ifc.toggle_cnt[0], 1);
         chk("n_max",     ifc.toggle_cnt <= 2 * MAX_PAIRS + 1, 1);
         chk("final_lvl", ifc.data_out, m_target);
      end
      p_data = ifc.data_out;
      p_busy = ifc.busy;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(ifc.level_in);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic check_reset_vals(string tag);
      chk({tag, "_data"},    ifc.data_out,   0);
      chk({tag, "_busy"},    ifc.busy,       0);
      chk({tag, "_settled"}, ifc.settled,    0);
      chk({tag, "_tcnt"},    ifc.toggle_cnt, 0);
   endtask

   task automatic mid_event_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_vals("rst_async");
      ifc.level_in = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_reset_vals("rst_hold");
      end
      rst_n = 1'b1;
   endtask

   initial begin
      int  guard;
      bit  did_rst;
      ifc.level_in = 1'b0;
      model_reset();
      #1;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();

      guard   = 0;
      did_rst = 0;
      while (events < 200 && guard < 60000) begin
         if ($urandom_range(0, 5) == 0) ifc.level_in = 1'($urandom_range(0, 1));
         if (events == 100 && m_busy && !did_rst) begin
            did_rst = 1;
            mid_event_reset();
         end
         step();
         guard++;
      end
      if (events < 200) chk("event_budget", events, 200);

      guard = 0;
      while (m_busy && guard < 1000) begin
         step();
         guard++;
      end
      if (m_busy) chk("drain_budget", m_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
